// File: rtl/divider_sweep_pkg.sv
// divider_sweep_pkg
// Shared definitions for the divider sweep driver: the sweep FSM state
// encoding and the operand range of the exhaustive sweep.
package divider_sweep_pkg;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    WAIT_DONE,
    CHECK,
    ACK,
    WAIT_CLEAR,
    NEXT,
    FIN
  } state_t;

  // Operand range. Y starts at 1 because a zero divisor never completes.
  localparam logic [3:0] X_MAX     = 4'd15;
  localparam logic [3:0] Y_MIN     = 4'd1;
  localparam logic [3:0] Y_MAX     = 4'd15;
  localparam int         NUM_CASES = 240;

endpackage

// File: rtl/divider_sweep_driver.sv
// divider_sweep_driver
// Self-checking initiator for the divider core. A Go pulse starts a sweep of
// every operand pair X = 0..15, Y = 1..15. Each result is compared with a
// combinational golden X/Y, X%Y; mismatches are counted and the first failing
// operands are latched. A hung core (Done never rising, or never falling after
// Ack) ends the sweep with Hung set.
//
// Ports:
//   board_clk, Reset      clock; asynchronous active-high reset
//   Go                    single-cycle start pulse (ignored while Busy)
//   Done                  divider Done
//   Quotient, Remainder   divider results (4 bits each)
//   Xin, Yin              operands to the divider (registered)
//   Start, Ack            divider handshake (decoded from state)
//   Busy                  sweep in progress (decoded from state)
//   Finished, Hung        sweep ended / ended by timeout (registered)
//   ErrCount, CaseCount   mismatch count (saturating) / cases checked
//   FirstErrX, FirstErrY  operands of the first mismatch
//
// Handshake: Start is high for exactly one cycle (LOAD) with Xin/Yin already
// stable. The core raises Done when its results are valid; the driver samples
// the results the cycle after it first sees Done, then pulses Ack for one
// cycle. The core must then drop Done before the next Start. Xin/Yin only
// change in NEXT, so they stay stable across the whole transaction.
module divider_sweep_driver
  import divider_sweep_pkg::*;
#(
  parameter int unsigned TIMEOUT = 63
) (
  input  logic       board_clk,
  input  logic       Reset,
  input  logic       Go,
  input  logic       Done,
  input  logic [3:0] Quotient,
  input  logic [3:0] Remainder,
  output logic [3:0] Xin,
  output logic [3:0] Yin,
  output logic       Start,
  output logic       Ack,
  output logic       Busy,
  output logic       Finished,
  output logic       Hung,
  output logic [7:0] ErrCount,
  output logic [7:0] CaseCount,
  output logic [3:0] FirstErrX,
  output logic [3:0] FirstErrY
);

  // The timer reads 0 on the first cycle in a wait state, so expiring at
  // TIMEOUT-1 leaves the FSM in FIN exactly TIMEOUT cycles after entry.
  localparam logic [7:0] TIMER_LAST = 8'(TIMEOUT - 1);

  state_t     state;
  state_t     state_next;
  logic [7:0] timer;
  logic       timer_expired;
  logic       hang_event;
  logic       sweep_last;
  logic [3:0] gold_q;
  logic [3:0] gold_r;
  logic       mismatch;

  // Golden model; Yin is never 0 so the division is always defined.
  assign gold_q   = Xin / Yin;
  assign gold_r   = Xin % Yin;
  assign mismatch = ({Quotient, Remainder} != {gold_q, gold_r});

  assign timer_expired = (timer == TIMER_LAST);
  assign sweep_last    = (Xin == X_MAX) && (Yin == Y_MAX);

  assign Start = (state == LOAD);
  assign Ack   = (state == ACK);
  assign Busy  = (state != IDLE);

  // Next-state logic.
  always_comb begin
    state_next = state;
    hang_event = 1'b0;
    case (state)
      IDLE:       if (Go) state_next = LOAD;
      LOAD:       state_next = WAIT_DONE;
      WAIT_DONE: begin
        if (Done) begin
          state_next = CHECK;
        end else if (timer_expired) begin
          state_next = FIN;
          hang_event = 1'b1;
        end
      end
      CHECK:      state_next = ACK;
      ACK:        state_next = WAIT_CLEAR;
      WAIT_CLEAR: begin
        if (!Done) begin
          state_next = NEXT;
        end else if (timer_expired) begin
          state_next = FIN;
          hang_event = 1'b1;
        end
      end
      NEXT:       state_next = sweep_last ? FIN : LOAD;
      FIN:        state_next = IDLE;
      default:    state_next = IDLE;
    endcase
  end

  always_ff @(posedge board_clk or posedge Reset) begin
    if (Reset) state <= IDLE;
    else       state <= state_next;
  end

  // Wait timer: runs only in the two wait states, cleared everywhere else,
  // which clears it on entry to either wait state.
  always_ff @(posedge board_clk or posedge Reset) begin
    if (Reset) begin
      timer <= 8'd0;
    end else if ((state == WAIT_DONE) || (state == WAIT_CLEAR)) begin
      timer <= timer + 8'd1;
    end else begin
      timer <= 8'd0;
    end
  end

  // Operands, counters and status flags.
  always_ff @(posedge board_clk or posedge Reset) begin
    if (Reset) begin
      Xin       <= 4'd0;
      Yin       <= Y_MIN;
      Finished  <= 1'b0;
      Hung      <= 1'b0;
      ErrCount  <= 8'd0;
      CaseCount <= 8'd0;
      FirstErrX <= 4'd0;
      FirstErrY <= 4'd0;
    end else begin
      case (state)
        IDLE: begin
          if (Go) begin
            Xin       <= 4'd0;
            Yin       <= Y_MIN;
            Finished  <= 1'b0;
            Hung      <= 1'b0;
            ErrCount  <= 8'd0;
            CaseCount <= 8'd0;
            FirstErrX <= 4'd0;
            FirstErrY <= 4'd0;
          end
        end
        CHECK: begin
          if (mismatch) begin
            if (ErrCount != 8'hFF) ErrCount <= ErrCount + 8'd1;
            if (ErrCount == 8'd0) begin
              FirstErrX <= Xin;
              FirstErrY <= Yin;
            end
          end
          CaseCount <= CaseCount + 8'd1;
        end
        NEXT: begin
          if (Yin < Y_MAX) begin
            Yin <= Yin + 4'd1;
          end else if (Xin < X_MAX) begin
            Yin <= Y_MIN;
            Xin <= Xin + 4'd1;
          end
        end
        default: ;
      endcase

      if (hang_event) Hung <= 1'b1;
      // Finished rises on the edge that enters FIN, with the final counts.
      if ((state_next == FIN) && (state != FIN)) Finished <= 1'b1;
    end
  end

endmodule

// File: doc/divider_sweep_driver.md
# divider_sweep_driver

Self-checking initiator for the divider core's Start/Done/Ack handshake. It sits on the divider's operand and handshake inputs in place of the switches and button-debouncer path. On a Go pulse it steps through every legal operand pair, X = 0..15 and Y = 1..15, for 240 cases. For each case it compares Quotient and Remainder against a golden X/Y and X%Y, counts mismatches, latches the first failing operands for SSD display, and flags a hung core with a timeout.

## Interface
Parameters:
- TIMEOUT, 63 — maximum cycles allowed in WAIT_DONE or WAIT_CLEAR before declaring a hang; legal range 20..255.

Ports:
- board_clk  in  1  system clock; all state changes on the rising edge.
- Reset  in  1  asynchronous, active-high reset.
- Go  in  1  single-cycle start pulse, e.g. a debouncer SCEN.
- Done  in  1  divider Done.
- Quotient  in  4  divider quotient.
- Remainder  in  4  divider remainder.
- Xin  out  4  dividend to the divider; reset 0.
- Yin  out  4  divisor to the divider; reset 1.
- Start  out  1  divider Start; reset 0.
- Ack  out  1  divider Ack; reset 0.
- Busy  out  1  sweep in progress; reset 0.
- Finished  out  1  sweep ended, normally or by hang; reset 0.
- Hung  out  1  timeout occurred; reset 0.
- ErrCount  out  8  mismatch count, saturating at 255; reset 0.
- CaseCount  out  8  cases checked; reset 0.
- FirstErrX  out  4  X of the first mismatch; reset 0.
- FirstErrY  out  4  Y of the first mismatch; reset 0.

## Operation
- State machine states and transitions:
  - IDLE: on Go, clear ErrCount, CaseCount, Hung, Finished and FirstErr*; set Xin=0, Yin=1; go to LOAD.
  - LOAD: Start=1 for this one cycle; go to WAIT_DONE.
  - WAIT_DONE: wait for Done=1, then go to CHECK. If the timer reaches TIMEOUT, set Hung and go to FIN.
  - CHECK: compare {Quotient,Remainder} with {Xin/Yin, Xin%Yin}. On mismatch, increment ErrCount (saturating). If this is the first mismatch (ErrCount was 0), latch FirstErrX/FirstErrY. Increment CaseCount. Go to ACK.
  - ACK: Ack=1 for this one cycle; go to WAIT_CLEAR.
  - WAIT_CLEAR: wait for Done=0. If the timer reaches TIMEOUT, set Hung and go to FIN. Otherwise go to NEXT.
  - NEXT: advance the operands as follows, then go to LOAD.
    - If Yin<15: Yin+1.
    - Else if Xin<15: Yin=1, Xin+1.
    - Else (X=15, Y=15 already checked): go to FIN instead.
  - FIN: Finished=1; go to IDLE.
- Finished, Hung, the counters and FirstErr* hold their values in IDLE until the next Go.
- Busy=1 in every state except IDLE.
- Go is ignored while Busy. A Go in the same cycle as FIN is also ignored.
- Yin is never 0. A zero divisor makes the divider iterate forever, so Y=0 is excluded from the sweep.
- The golden model uses 4-bit unsigned division, combinational. Both operands come from registers.
- Xin/Yin hold stable from LOAD through WAIT_CLEAR; they change only in NEXT.
- Start and Ack are never both high. Ack is asserted only when Done was sampled high.
- Reset mid-sweep: all outputs return to their reset values immediately and the FSM goes to IDLE. There is no resume.

## Timing
- Go at edge n → LOAD at n+1 (Start high for cycle n+1), WAIT_DONE from n+2.
- Done sampled high → CHECK next cycle → Ack high the following cycle. Ack is therefore 2 cycles after Done is first seen.
- Timeout timer: 8 bits, cleared on entry to WAIT_DONE and WAIT_CLEAR, incremented each cycle in those states.
- Hang detection latency: exactly TIMEOUT cycles after entry to the waiting state.
- Per-case overhead, excluding divider compute: LOAD, CHECK, ACK, NEXT plus ≥1 cycle each of WAIT_DONE and WAIT_CLEAR.
- Full sweep: 240 cases, with CaseCount=240 when Finished rises.

## Structure
- Package divider_sweep_pkg holds:
  - the state enum (IDLE, LOAD, WAIT_DONE, CHECK, ACK, WAIT_CLEAR, NEXT, FIN);
  - the constants X_MAX=15, Y_MIN=1, Y_MAX=15, NUM_CASES=240.
- Single module with no sub-modules. The golden model and timer are inline.
- Outputs are registered, except Start, Ack and Busy, which decode directly from the state register.

## Test plan
- Correct divider core, Go pulse → 240 Start pulses and 240 Ack pulses; Finished=1, ErrCount=0, CaseCount=240, Hung=0.
- Behavioral core returning Quotient=2 for X=13, Y=4 (correct value is 3) → ErrCount=1, FirstErrX=D, FirstErrY=4, CaseCount=240.
- Core that never raises Done → Hung=1 and Finished=1 exactly TIMEOUT cycles after entering WAIT_DONE, with Xin=0, Yin=1, CaseCount=0.
- Core whose Done stays high after Ack → Hung=1 after WAIT_CLEAR times out, CaseCount=1.
- Go pulses during the sweep → no restart and no counter clear; the final CaseCount is still 240.
- Reset asserted mid-sweep at X=7, Y=9 → all outputs return to reset values (Yin=1, counters 0) immediately; a new Go restarts from X=0, Y=1.
